// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared FSM states, default sizes and enable constants for the register file.
package regfile_sb_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam bit ENABLE = 1'b1;
  localparam bit DISABLE = 1'b0;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write, read, scoreboard and ready signals of the register file.
interface regfile_sb_if import regfile_sb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF
) ();
  localparam int AW = $clog2(NREG);
  logic reg_we;
  logic [AW-1:0] rd_src;
  logic [XLEN-1:0] rd;
  logic [NRD-1:0][AW-1:0] rs_src;
  logic [NRD-1:0][XLEN-1:0] rs;
  logic [NRD-1:0] rs_busy;
  logic sb_set;
  logic [AW-1:0] sb_idx;
  logic ready;
  modport master (
    output reg_we, rd_src, rd, rs_src, sb_set, sb_idx,
    input rs, rs_busy, ready
  );
  modport slave (
    input reg_we, rd_src, rd, rs_src, sb_set, sb_idx,
    output rs, rs_busy, ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with set-over-clear priority and per-port lookups.
module regfile_scoreboard import regfile_sb_pkg::*; #(
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter bit BYPASS = ENABLE,
  localparam int AW = $clog2(NREG)
) (
  input logic clk,
  input logic rst,
  input logic run_i,
  input logic we_i,
  input logic [AW-1:0] wr_idx_i,
  input logic set_i,
  input logic [AW-1:0] set_idx_i,
  input logic [NRD-1:0][AW-1:0] rs_src_i,
  output logic [NRD-1:0] rs_busy_o
);
  logic [NREG-1:0] busy_q, busy_d;
  // the set is applied after the clear so a same-index set wins
  always_comb begin
    busy_d = busy_q;
    if (run_i && we_i) busy_d[wr_idx_i] = 1'b0;
    if (run_i && set_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic fwd;
    assign fwd = BYPASS && run_i && we_i && wr_idx_i != '0 && rs_src_i[i] == wr_idx_i;
    // a forwarded port shows the busy state the register will have after this edge
    assign rs_busy_o[i] = !run_i ? 1'b0 : fwd ? (set_i && set_idx_i == wr_idx_i) : busy_q[rs_src_i[i]];
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with sequential clear after reset, optional
// write-to-read forwarding and a busy scoreboard.
module regfile_sb import regfile_sb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter bit BYPASS = ENABLE,
  localparam int AW = $clog2(NREG)
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic clearing, run;
  logic wen;
  logic [AW-1:0] widx;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] mem_q [NREG];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // the edge that zeroes the last index also enters RUN, so a clear lasts NREG cycles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == LAST ? RUN : CLEAR;
    end
  end
  always_comb begin
    clearing = state_q == CLEAR;
    run = state_q == RUN;
  end
  assign bus.ready = run;
  always_comb begin
    wen = !rst && (clearing || (run && bus.reg_we && bus.rd_src != '0));
    widx = clearing ? cnt_q : bus.rd_src;
    wdata = clearing ? '0 : bus.rd;
  end
  always_ff @(posedge clk) begin
    if (wen) mem_q[widx] <= wdata;
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic fwd;
    assign fwd = BYPASS && bus.reg_we && bus.rd_src == bus.rs_src[i];
    assign bus.rs[i] = (!run || bus.rs_src[i] == '0) ? '0 : fwd ? bus.rd : mem_q[bus.rs_src[i]];
  end
  regfile_scoreboard #(.NREG(NREG), .NRD(NRD), .BYPASS(BYPASS)) u_sb (
    .clk(clk),
    .rst(rst),
    .run_i(run),
    .we_i(bus.reg_we && bus.rd_src != '0),
    .wr_idx_i(bus.rd_src),
    .set_i(bus.sb_set && bus.sb_idx != '0),
    .set_idx_i(bus.sb_idx),
    .rs_src_i(bus.rs_src),
    .rs_busy_o(bus.rs_busy)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: two register files (forwarding on/off) driven identically and checked
// against an array/busy-bit reference model.
module tb_regfile_sb;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int NP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] mem [NR];
  bit busy [NR];
  int cnt = 0;
  bit known = 1'b0;
  always #5 clk = ~clk;
  regfile_sb_if #(.XLEN(XL), .NREG(NR), .NRD(NP)) b1 ();
  regfile_sb_if #(.XLEN(XL), .NREG(NR), .NRD(NP)) b0 ();
  assign b0.reg_we = b1.reg_we;
  assign b0.rd_src = b1.rd_src;
  assign b0.rd = b1.rd;
  assign b0.rs_src = b1.rs_src;
  assign b0.sb_set = b1.sb_set;
  assign b0.sb_idx = b1.sb_idx;
  regfile_sb #(.XLEN(XL), .NREG(NR), .NRD(NP), .BYPASS(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  regfile_sb #(.XLEN(XL), .NREG(NR), .NRD(NP), .BYPASS(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));

  function automatic bit e_ready();
    return cnt >= NR;
  endfunction
  function automatic logic [31:0] e_rs(int idx, bit byp);
    if (!e_ready() || idx == 0) return 32'h0;
    if (byp && b1.reg_we && int'(b1.rd_src) == idx) return b1.rd;
    return mem[idx];
  endfunction
  function automatic logic e_busy(int idx, bit byp);
    if (!e_ready() || idx == 0) return 1'b0;
    if (byp && b1.reg_we && int'(b1.rd_src) == idx) return b1.sb_set && int'(b1.sb_idx) == idx;
    return busy[idx];
  endfunction
  task automatic chk(string tag, int p, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s port=%0d obs=%0h exp=%0h", tag, p, o, e);
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    if (known) begin
      chk("ready_byp1", 0, 32'(b1.ready), 32'(e_ready()));
      chk("ready_byp0", 0, 32'(b0.ready), 32'(e_ready()));
      for (int p = 0; p < NP; p++) begin
        chk("rs_byp1", p, b1.rs[p], e_rs(int'(b1.rs_src[p]), 1'b1));
        chk("rs_byp0", p, b0.rs[p], e_rs(int'(b1.rs_src[p]), 1'b0));
        chk("busy_byp1", p, 32'(b1.rs_busy[p]), 32'(e_busy(int'(b1.rs_src[p]), 1'b1)));
        chk("busy_byp0", p, 32'(b0.rs_busy[p]), 32'(e_busy(int'(b1.rs_src[p]), 1'b0)));
      end
    end
    @(posedge clk);
    if (rst) begin
      known = 1'b1;
      cnt = 0;
      foreach (busy[i]) busy[i] = 1'b0;
    end else if (known && cnt < NR) begin
      cnt++;
      if (cnt == NR) foreach (mem[i]) mem[i] = 32'h0;
    end else if (known) begin
      if (b1.reg_we && b1.rd_src != 0) begin
        mem[b1.rd_src] = b1.rd;
        busy[b1.rd_src] = 1'b0;
      end
      if (b1.sb_set && b1.sb_idx != 0) busy[b1.sb_idx] = 1'b1;
    end
    #1;
  endtask
  task automatic set_in(bit we, int wi, logic [31:0] wd, bit s, int si);
    b1.reg_we = we;
    b1.rd_src = 5'(wi);
    b1.rd = wd;
    b1.sb_set = s;
    b1.sb_idx = 5'(si);
  endtask
  task automatic rdall(int a, int b, int c, int d);
    b1.rs_src[0] = 5'(a);
    b1.rs_src[1] = 5'(b);
    b1.rs_src[2] = 5'(c);
    b1.rs_src[3] = 5'(d);
  endtask
  task automatic rnd_in();
    set_in($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7));
    rdall($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 7));
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    rdall(0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;
    // writes and sets attempted throughout the clear must be ignored
    repeat (NR) begin
      set_in(1, $urandom_range(1, 31), $urandom, 1, $urandom_range(1, 31));
      rdall($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      cycle();
    end
    set_in(0, 0, 0, 0, 0);
    for (int k = 0; k < NR / NP; k++) begin
      rdall(4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3);
      cycle();
    end
    set_in(1, 5, 32'hDEADBEEF, 0, 0);
    rdall(5, 0, 5, 1);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    set_in(1, 0, 32'h12345678, 1, 0);
    rdall(0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 1, 7);
    rdall(7, 7, 0, 5);
    cycle();
    set_in(0, 0, 0, 0, 0);
    repeat (3) cycle();
    set_in(1, 7, 32'h1, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    set_in(1, 7, 32'h1, 1, 7);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    set_in(1, 9, 32'hA5A5A5A5, 0, 0);
    rdall(9, 9, 9, 9);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    // reset while running drops the same-cycle write and set
    set_in(1, 4, 32'h44, 1, 4);
    rdall(4, 5, 4, 5);
    cycle();
    rst = 1'b1;
    set_in(1, 4, 32'h99, 1, 5);
    cycle();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (NR + 1) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_in(1, 3, 32'hFF, 0, 0);
    rdall(3, 3, 0, 1);
    repeat (10) cycle();
    rst = 1'b1;
    set_in(1, 3, 32'hFF, 1, 3);
    cycle();
    rst = 1'b0;
    set_in(1, 3, 32'hFF, 0, 0);
    repeat (NR) cycle();
    set_in(0, 0, 0, 0, 0);
    rdall(3, 3, 3, 3);
    cycle();
    repeat (500) begin
      rst = $urandom_range(0, 99) == 0;
      rnd_in();
      cycle();
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (NR + 1) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
